// File: rtl/cfg_pkg.sv
// Shared types and sizing for the tile configuration scan-chain loader.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    // Each tile holds four 2-bit mux41 selects, one per direction.
    localparam int CFG_BITS_PER_TILE = 8;
    localparam int NUM_TILES         = 16;
    localparam int CFG_CHAIN_BITS    = NUM_TILES * CFG_BITS_PER_TILE;

    function automatic int cfg_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load, serial-out shift register (LSB out first) for one host config word.
module cfg_piso #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             sdo_next
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic upper;
        if (gi == WIDTH - 1) begin : g_top
            assign upper = 1'b0;
        end else begin : g_mid
            assign upper = sreg_q[gi+1];
        end
        assign sreg_d[gi] = load ? par_in[gi] : (shift ? upper : sreg_q[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Next-cycle LSB, so the parent can register cfg_sdo in step with the bit it presents.
    assign sdo_next = sreg_d[0];

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes host config words onto the tile scan chain, then pulses a one-cycle commit.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int CHAIN_BITS = CFG_CHAIN_BITS,
    localparam int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             cfg_shift,
    output logic             cfg_sdo,
    output logic             cfg_commit,
    output logic             busy,
    output logic             done
);

    localparam int WB_W = $clog2(WIDTH + 1);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [WB_W-1:0]   word_bits_q, word_bits_d;
    logic              done_q, done_d;
    logic              cfg_shift_q, cfg_shift_d;
    logic              cfg_sdo_q, cfg_sdo_d;
    logic              cfg_commit_q, cfg_commit_d;
    logic              piso_load;
    logic              piso_shift;
    logic              sdo_next;

    assign piso_load  = (state_q == FETCH) && in_valid;
    assign piso_shift = (state_q == SHIFT);

    cfg_piso #(.WIDTH(WIDTH)) u_piso (
        .clk      (clk),
        .rst_n    (reset),
        .load     (piso_load),
        .shift    (piso_shift),
        .par_in   (in_data),
        .sdo_next (sdo_next)
    );

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        word_bits_d = word_bits_q;
        done_d      = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    done_d      = 1'b0;
                    bits_left_d = CNT_W'(CHAIN_BITS);
                end
            end
            FETCH: begin
                if (in_valid) begin
                    // The final word may be only partly shifted when the chain is not a multiple of WIDTH.
                    word_bits_d = WB_W'(cfg_min(int'(bits_left_q), WIDTH));
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                word_bits_d = word_bits_q - 1'b1;
                bits_left_d = bits_left_q - 1'b1;
                if (word_bits_q == WB_W'(1)) begin
                    state_d = (bits_left_q == CNT_W'(1)) ? COMMIT : FETCH;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Chain-facing outputs are decoded from the next state and registered.
        cfg_shift_d  = (state_d == SHIFT);
        cfg_sdo_d    = (state_d == SHIFT) && sdo_next;
        cfg_commit_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bits_left_q  <= '0;
            word_bits_q  <= '0;
            done_q       <= 1'b0;
            cfg_shift_q  <= 1'b0;
            cfg_sdo_q    <= 1'b0;
            cfg_commit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bits_left_q  <= bits_left_d;
            word_bits_q  <= word_bits_d;
            done_q       <= done_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_sdo_q    <= cfg_sdo_d;
            cfg_commit_q <= cfg_commit_d;
        end
    end

    assign in_ready   = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_shift  = cfg_shift_q;
    assign cfg_sdo    = cfg_sdo_q;
    assign cfg_commit = cfg_commit_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench: a default 128-bit chain instance and a 40-bit partial-word instance.
module tb_cfg_chain_loader;

    typedef struct {
        int bits;
        int lat;
    } load_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start_v, in_valid_v, in_ready_v, cfg_shift_v, cfg_sdo_v, cfg_commit_v, busy_v, done_v;
    logic [31:0] in_data_v [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_start [2];
    int shift_cnt  [2];
    int commits    [2];

    bit    exp_b0[$];
    bit    exp_b1[$];
    load_t exp_l0[$];
    load_t exp_l1[$];

    logic [31:0] basic_w [4] = '{32'h00000001, 32'h80000000, 32'hA5A5A5A5, 32'hFFFFFFFF};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cfg_chain_loader #(.WIDTH(32)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .in_data(in_data_v[0]), .in_ready(in_ready_v[0]), .cfg_shift(cfg_shift_v[0]),
        .cfg_sdo(cfg_sdo_v[0]), .cfg_commit(cfg_commit_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    cfg_chain_loader #(.WIDTH(32), .CHAIN_BITS(40)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .in_data(in_data_v[1]), .in_ready(in_ready_v[1]), .cfg_shift(cfg_shift_v[1]),
        .cfg_sdo(cfg_sdo_v[1]), .cfg_commit(cfg_commit_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_bit(input int d, input bit b);
        if (d == 0) exp_b0.push_back(b); else exp_b1.push_back(b);
    endfunction

    function automatic bit pop_bit(input int d);
        if (d == 0) return exp_b0.pop_front();
        return exp_b1.pop_front();
    endfunction

    function automatic int bit_len(input int d);
        return (d == 0) ? exp_b0.size() : exp_b1.size();
    endfunction

    function automatic void push_load(input int d, input load_t e);
        if (d == 0) exp_l0.push_back(e); else exp_l1.push_back(e);
    endfunction

    function automatic load_t pop_load(input int d);
        if (d == 0) return exp_l0.pop_front();
        return exp_l1.pop_front();
    endfunction

    function automatic int load_len(input int d);
        return (d == 0) ? exp_l0.size() : exp_l1.size();
    endfunction

    function automatic void flush(input int d);
        if (d == 0) begin
            exp_b0.delete();
            exp_l0.delete();
        end else begin
            exp_b1.delete();
            exp_l1.delete();
        end
    endfunction

    // Monitor: pops expected bits on every shift and expected load records on every commit.
    always @(negedge clk) begin
        load_t e;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                flush(d);
                shift_cnt[d] = 0;
            end else begin
                if (cfg_shift_v[d]) begin
                    if (bit_len(d) == 0) chk("unexpected_shift", 1, 0);
                    else chk((d == 0) ? "sdo_dut0" : "sdo_dut1", int'(cfg_sdo_v[d]), int'(pop_bit(d)));
                    shift_cnt[d]++;
                end
                if (cfg_commit_v[d]) begin
                    commits[d]++;
                    if (load_len(d) == 0) begin
                        chk("unexpected_commit", 1, 0);
                    end else begin
                        e = pop_load(d);
                        chk("shift_count", shift_cnt[d], e.bits);
                        if (e.lat >= 0) chk("commit_latency", cyc - load_start[d], e.lat);
                    end
                    shift_cnt[d] = 0;
                end
            end
        end
    end

    task automatic do_start(input int d, input int lat, input int nbits);
        load_t e;
        e.bits = nbits;
        e.lat  = lat;
        @(posedge clk); #1;
        start_v[d] = 1'b1;
        push_load(d, e);
        @(negedge clk);
        load_start[d] = cyc;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic send_word(input int d, input logic [31:0] w, input int nbits, input int stall);
        int n;
        for (int i = 0; i < nbits; i++) push_bit(d, w[i]);
        if (stall > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready_v[d] && n < 200);
            if (!in_ready_v[d]) chk("fetch_timeout", 0, 1);
            for (int i = 0; i < stall; i++) begin
                chk("stall_in_ready", int'(in_ready_v[d]), 1);
                chk("stall_cfg_shift", int'(cfg_shift_v[d]), 0);
                @(negedge clk);
            end
        end
        in_data_v[d]  = w;
        in_valid_v[d] = 1'b1;
        n = 0;
        while (!in_ready_v[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[d]) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_v[d] && n < 1000);
        chk("busy_after_load", int'(busy_v[d]), 0);
        chk("done_after_load", int'(done_v[d]), 1);
    endtask

    task automatic check_quiet(input int d);
        chk("q_in_ready", int'(in_ready_v[d]), 0);
        chk("q_cfg_shift", int'(cfg_shift_v[d]), 0);
        chk("q_cfg_sdo", int'(cfg_sdo_v[d]), 0);
        chk("q_cfg_commit", int'(cfg_commit_v[d]), 0);
        chk("q_busy", int'(busy_v[d]), 0);
        chk("q_done", int'(done_v[d]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b0;
        start_v       = '0;
        in_valid_v    = '0;
        in_data_v[0]  = '0;
        in_data_v[1]  = '0;
        for (int d = 0; d < 2; d++) begin
            load_start[d] = 0;
            shift_cnt[d]  = 0;
            commits[d]    = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet(0);
        check_quiet(1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Partial last word: only the low 8 bits (0x3C) of the second word reach the chain.
        do_start(1, 43, 40);
        send_word(1, 32'h12345678, 32, 0);
        send_word(1, 32'hFFFFFF3C, 8, 0);
        wait_idle(1);

        // Basic full load.
        do_start(0, 133, 128);
        for (int i = 0; i < 4; i++) send_word(0, basic_w[i], 32, 0);
        wait_idle(0);

        // in_valid in IDLE is never consumed.
        in_data_v[0]  = 32'hDEADBEEF;
        in_valid_v[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", int'(in_ready_v[0]), 0);
            chk("idle_busy", int'(busy_v[0]), 0);
        end
        in_valid_v[0] = 1'b0;

        // Host stall of 10 cycles in the second FETCH.
        do_start(0, 143, 128);
        send_word(0, basic_w[0], 32, 0);
        send_word(0, basic_w[1], 32, 10);
        send_word(0, basic_w[2], 32, 0);
        send_word(0, basic_w[3], 32, 0);
        wait_idle(0);

        // start during SHIFT of word 2 is ignored.
        do_start(0, 133, 128);
        send_word(0, basic_w[0], 32, 0);
        send_word(0, basic_w[1], 32, 0);
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("ignored_start_busy", int'(busy_v[0]), 1);
        send_word(0, basic_w[2], 32, 0);
        send_word(0, basic_w[3], 32, 0);
        wait_idle(0);

        // Back-to-back all-zero load right after done rises.
        do_start(0, 133, 128);
        chk("b2b_done_cleared", int'(done_v[0]), 0);
        chk("b2b_busy", int'(busy_v[0]), 1);
        for (int i = 0; i < 4; i++) send_word(0, 32'h0, 32, 0);
        wait_idle(0);

        // Reset after about 50 shifts abandons the load.
        do_start(0, -1, 128);
        send_word(0, basic_w[2], 32, 0);
        send_word(0, basic_w[3], 32, 0);
        n = 0;
        while (shift_cnt[0] < 50 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("reach_50_shifts", int'(shift_cnt[0] >= 50), 1);
        #1;
        reset = 1'b0;
        #1;
        check_quiet(0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;

        // Clean full load after reset.
        do_start(0, 133, 128);
        for (int i = 0; i < 4; i++) send_word(0, basic_w[3 - i], 32, 0);
        wait_idle(0);

        repeat (3) @(negedge clk);
        chk("commits_dut0", commits[0], 5);
        chk("commits_dut1", commits[1], 1);
        chk("leftover_bits0", bit_len(0), 0);
        chk("leftover_bits1", bit_len(1), 0);
        chk("leftover_loads0", load_len(0), 0);
        chk("leftover_loads1", load_len(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
